// File: rtl/led_pkg.sv
// led_pkg: phase encodings, start patterns and pattern helper shared by the LED chase driver and monitor
package led_pkg;
  localparam logic [1:0] PH_L2R = 2'b00;
  localparam logic [1:0] PH_R2L = 2'b01;
  localparam logic [1:0] PH_IO  = 2'b11;
  localparam logic [1:0] PH_OI  = 2'b10;
  localparam logic [15:0] LED_L2R_START = 16'h8000;
  localparam logic [15:0] LED_IO_START  = 16'h0180;
  localparam logic [3:0] STEP_LAST_LR = 4'd15;
  localparam logic [3:0] STEP_LAST_IO = 4'd7;
  typedef enum logic {ST_HUNT, ST_TRACK} mon_state_e;
  function automatic logic [15:0] led_pattern(input logic [1:0] ph, input logic [3:0] st);
    logic [7:0] up;
    logic [7:0] dn;
    up = 8'h01 << st[2:0];
    dn = 8'h80 >> st[2:0];
    return ph == PH_L2R ? LED_L2R_START >> st :
           ph == PH_R2L ? 16'h0001 << st :
           ph == PH_IO  ? {up, dn} : {dn, up};
  endfunction
endpackage

// File: rtl/led_expect.sv
// led_expect: combinational successor of a (phase, step) position in the chase sequence
module led_expect
  import led_pkg::*;
(
  input  logic [1:0]  phase_i,
  input  logic [3:0]  step_i,
  output logic [15:0] exp_light_o,
  output logic [1:0]  exp_phase_o,
  output logic [3:0]  exp_step_o,
  output logic        lap_wrap_o
);
  logic [1:0] wrap_ph;
  logic       at_last;
  assign at_last = step_i == ((phase_i == PH_L2R || phase_i == PH_R2L) ? STEP_LAST_LR : STEP_LAST_IO);
  assign wrap_ph = phase_i == PH_L2R ? PH_R2L :
                   phase_i == PH_R2L ? PH_IO  :
                   phase_i == PH_IO  ? PH_OI  : PH_L2R;
  assign exp_phase_o = at_last ? wrap_ph : phase_i;
  // R2L and OI begin at step 1 because their step-0 pattern is the previous phase's last pattern
  assign exp_step_o = !at_last ? step_i + 4'd1 :
                      (wrap_ph == PH_IO || wrap_ph == PH_L2R) ? 4'd0 : 4'd1;
  assign exp_light_o = led_pattern(exp_phase_o, exp_step_o);
  assign lap_wrap_o = at_last && phase_i == PH_OI;
endmodule

// File: rtl/led_pattern_monitor.sv
// led_pattern_monitor: tracks the 16-LED chase sequence; lap counter enabled by LED_MON_LAP_CNT_EN
module led_pattern_monitor
  import led_pkg::*;
#(
  parameter int STALL_W   = 25,
  parameter int STALL_MAX = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] light,
  output logic        locked,
  output logic [1:0]  phase,
  output logic [3:0]  step,
  output logic        err,
  output logic        stall,
  output logic [7:0]  lap_cnt
);
  localparam logic [STALL_W-1:0] STALL_TERM = STALL_W'(STALL_MAX - 2);
  mon_state_e         state_q, state_d;
  logic [15:0]        light_q;
  logic [1:0]         phase_q, phase_d;
  logic [3:0]         step_q, step_d;
  logic [STALL_W-1:0] cnt_q, cnt_d;
  logic               err_q, err_d, stall_q, stall_d;
  logic               lap_inc, chg, lap_wrap;
  logic [15:0]        exp_light;
  logic [1:0]         exp_phase;
  logic [3:0]         exp_step;
  assign chg = light != light_q;
  led_expect u_expect (
    .phase_i    (phase_q),
    .step_i     (step_q),
    .exp_light_o(exp_light),
    .exp_phase_o(exp_phase),
    .exp_step_o (exp_step),
    .lap_wrap_o (lap_wrap)
  );
  // Next-state: hunt for 8000, follow change events, flag wrong patterns and idle timeouts
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    step_d  = step_q;
    cnt_d   = '0;
    err_d   = 1'b0;
    stall_d = 1'b0;
    lap_inc = 1'b0;
    if (state_q == ST_HUNT) begin
      if (chg && light == LED_L2R_START) state_d = ST_TRACK;
    end else if (chg) begin
      if (light == exp_light) begin
        phase_d = exp_phase;
        step_d  = exp_step;
        lap_inc = lap_wrap;
      end else begin
        err_d   = light != 16'h0000;
        state_d = (err_d && light == LED_L2R_START) ? ST_TRACK : ST_HUNT;
        phase_d = PH_L2R;
        step_d  = '0;
      end
    end else if (cnt_q == STALL_TERM) begin
      stall_d = 1'b1;
      state_d = ST_HUNT;
      phase_d = PH_L2R;
      step_d  = '0;
    end else begin
      cnt_d = cnt_q + STALL_W'(1);
    end
  end
  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HUNT;
      light_q <= '0;
      phase_q <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      light_q <= light;
      phase_q <= phase_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end
  assign locked = state_q == ST_TRACK;
  assign phase  = phase_q;
  assign step   = step_q;
  assign err    = err_q;
  assign stall  = stall_q;
`ifdef LED_MON_LAP_CNT_EN
  logic [7:0] lap_q, lap_d;
  assign lap_d = (lap_inc && lap_q != 8'hFF) ? lap_q + 8'd1 : lap_q;
  // Saturating lap counter, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) lap_q <= '0;
    else lap_q <= lap_d;
  end
  assign lap_cnt = lap_q;
`else
  logic lap_unused;
  assign lap_unused = lap_inc;
  assign lap_cnt = 8'd0;
`endif
endmodule

// File: doc/led_pattern_monitor.md
# led_pattern_monitor

Receive-side checker for the 16-LED chase driver. Samples the `light[15:0]` bus every `clk` and tracks the driver's four-phase sequence. Reports lock, current phase and step, pattern errors, stalls and completed laps. Sits beside the driver on the board top or in the bench as a self-checking observer, and drives the debug LEDs/7-seg.

## Interface
- `STALL_W`, 25 — width of the stall counter.
- `STALL_MAX`, 25_000_000 — cycles without a pattern change, while locked, before a stall is declared.

Ports:
- `clk` in 1 — single clock; all logic on posedge.
- `rst` in 1 — reset, synchronous, active-high.
- `light` in 16 — observed LED bus; bit 15 = leftmost LED.
- `locked` out 1 — sequence tracked.
- `phase` out 2 — current phase; 00 L2R, 01 R2L, 11 IO, 10 OI.
- `step` out 4 — step index within the phase.
- `err` out 1 — one-cycle pulse on an unexpected pattern.
- `stall` out 1 — one-cycle pulse on a stall timeout.
- `lap_cnt` out 8 — completed laps, saturating.

## Operation
- `light_q` registers `light` every cycle. A change event occurs when `light != light_q`. Only change events advance the tracker; holding a value is legal.
- **Canonical sequence** (46 distinct patterns per lap):
  - L2R k=0..15: `16'h8000 >> k`
  - R2L k=1..15: `16'h0001 << k`; step 15 is `16'h8000`
  - IO k=0..7: `[15:8] = 8'h01 << k`, `[7:0] = 8'h80 >> k`; step 0 is `16'h0180`, step 7 is `16'h8001`
  - OI k=1..7: `[15:8] = 8'h80 >> k`, `[7:0] = 8'h01 << k`; step 7 is `16'h0180`
  - OI step 7 → L2R step 0; this wrap is one lap.
- **HUNT state** (after reset):
  - `locked=0`; `phase` and `step` hold 0.
  - A change event to `16'h8000` enters TRACK with `phase=00`, `step=0`.
  - All other changes are ignored. No `err` in HUNT.
- **TRACK state**, on a change event:
  - `light` equals the expected next pattern: advance `phase`/`step`.
  - `light == 0`: return to HUNT silently, with no `err`.
  - Any other value: `err` pulse, then go to HUNT. If that value is `16'h8000`, relock immediately in the same cycle instead (`phase=00`, `step=0`, `locked=1`); `err` still pulses.
- **Stall counter:**
  - Clears on every change event and in HUNT.
  - In TRACK, increments on each cycle without a change.
  - On reaching `STALL_MAX-1`: `stall` pulse and return to HUNT.
  - A change event in the same cycle as terminal count wins: no stall, counter clears.
- **`lap_cnt`:** increments on the OI7 → L2R0 transition and saturates at 255. It is not cleared by unlock, only by `rst`.

## Timing
- Reset values: `light_q=0`, HUNT, `locked=0`, `phase=0`, `step=0`, `err=0`, `stall=0`, `lap_cnt=0`, stall counter 0.
- Latency: `light` changes before edge N; the change is detected at edge N; all outputs reflect it after edge N (one-cycle latency).
- Because `light_q=0` after reset, a `light` held at `16'h8000` produces a change event on the first cycle after reset and locks.
- `rst` mid-sequence overrides everything on that edge. `err` and `stall` do not fire on the reset edge.
- `err` and `stall` are mutually exclusive and are never high for two consecutive cycles from the same event.

## Configuration
- `LED_MON_LAP_CNT_EN` defined: lap counter is implemented as described.
- `LED_MON_LAP_CNT_EN` undefined: the lap counter and its increment logic are removed; the `lap_cnt` port remains and is tied to `8'd0`.

## Structure
- Shared package `led_pkg`, also used by the driver:
  - phase encodings `PH_L2R=2'b00`, `PH_R2L=2'b01`, `PH_IO=2'b11`, `PH_OI=2'b10`
  - `LED_L2R_START=16'h8000`
  - `LED_IO_START=16'h0180`
  - last-step constants `4'd15` and `4'd7`
- Sub-module `led_expect`: combinational. Takes `phase` and `step`; returns the expected next pattern, next phase, next step and a `lap_wrap` flag.

## Test plan
- Reset, then drive the full canonical lap, each pattern held 3 cycles → `locked=1` after the first `8000`; `phase`/`step` walk 00/0 … 10/7; `lap_cnt=1` after the next `8000`; no `err`.
- Lock, reach L2R step 4 (`16'h0800`), drive `16'h0200` → one-cycle `err`, `locked=0`; then `8000` → relock at 00/0.
- Lock, then mid-R2L drive `16'h8000` off-sequence → `err` pulse and same-cycle relock at 00/0.
- Lock with `STALL_MAX=8`, hold `light` → `stall` pulse after 7 idle cycles, `locked=0`. Repeat with the change on the terminal cycle → no stall.
- Lock, drive `light=0` → HUNT with no `err`. Then assert `rst` mid-IO → all outputs 0 on the next cycle.
- Run 260 laps → `lap_cnt` saturates at 255. With `LED_MON_LAP_CNT_EN` undefined → `lap_cnt` stays 0.
